z80_uart_io: RTL
================

# z80_uart_io

UART peripheral that answers Z80 I/O-port cycles (IORQ) issued by the NextZ80 core, giving the CPU a serial console. It decodes a small block of port addresses, presents read data combinationally on the CPU data-in path, and drives an interrupt request. It contains an 8N1 transmitter with a one-byte holding register and an 8N1 receiver feeding a small RX FIFO. It sits beside the memory in the top level, with the CPU data-in mux selecting it whenever IORQ is asserted.

## Interface
- BASE_PORT, 8'h80: I/O base address. The block decodes `i_addr[7:2] == BASE_PORT[7:2]`; BASE_PORT[1:0] must be 0.
- CLKS_PER_BIT, 434: clock cycles per bit. Minimum 4.
- RX_DEPTH, 4: RX FIFO entries. Power of 2, at least 2.

- i_clk: input, 1. System clock, shared with the CPU.
- i_reset: input, 1. Asynchronous, active-high.
- i_addr: input, 8. CPU ADDR[7:0].
- i_iorq: input, 1. CPU IORQ, active-high.
- i_wr: input, 1. CPU WR, active-high.
- i_data: input, 8. CPU DO.
- o_data: output, 8. Read data. Valid while a decoded read is in progress; 8'h00 otherwise.
- o_int: output, 1. Level interrupt request to the CPU INT input.
- i_rx: input, 1. Serial in, asynchronous.
- o_tx: output, 1. Serial out.

## Operation
- Access decode: `sel = i_iorq & (i_addr[7:2] == BASE_PORT[7:2])`.
  - Write strobe: the first cycle of `sel & i_wr`, detected against a registered previous value of `sel`.
  - Read end: the first cycle after a `sel & ~i_wr` access in which `sel` is low.
- Port map (offsets):
  - 0 DATA. A write loads the TX holding register. If the holding register is already full, the write is dropped and nothing else changes. A read returns the RX FIFO head (8'h00 if empty); the FIFO is popped at read end.
  - 1 STATUS, read only. bit0 rx_avail, bit1 rx_full, bit2 tx_busy (shifter active), bit3 tx_ready (holding register empty), bit4 overrun (sticky), bit5 framing error (sticky), bits 7:6 zero. Writing 1 to bit4 or bit5 clears that bit.
  - 2 CTRL. Read/write. bit0 rx_ie, bit1 tx_ie; other bits read 0.
  - 3: reads 8'h00; writes are ignored.
- Interrupt: `o_int = (rx_ie & rx_avail) | (tx_ie & tx_ready)`.
- TX FSM, states IDLE → START → DATA → STOP → IDLE.
  - In IDLE with the holding register full, the byte moves to the shifter, the holding register is freed, and the FSM enters START.
  - Data bits are sent LSB first.
  - From STOP, if the holding register is full, the FSM goes directly to START, so back-to-back frames have no idle gap.
- RX:
  - i_rx passes through a 2-flop synchroniser.
  - FSM states IDLE → START → DATA → STOP → IDLE.
  - A synchronised falling edge in IDLE starts a frame. The line is checked at CLKS_PER_BIT/2 (integer division); if it is high, the frame is a glitch and the FSM returns to IDLE.
  - Data bits are sampled every CLKS_PER_BIT cycles after the start check.
  - Stop sample = 1: push the byte into the FIFO. Stop sample = 0: discard the byte and set the framing error bit.
  - Push while the FIFO is full: drop the byte and set the overrun bit. A pop and a push in the same cycle on a full FIFO both succeed.
- Reset mid-frame: TX and RX are aborted immediately and o_tx returns to 1. The FIFO, holding register, CTRL and sticky bits are cleared.

## Timing
- Reset values: o_tx=1, o_int=0, o_data=8'h00. All FSMs in IDLE, FIFO empty, CTRL=0, holding register empty.
- o_data is combinational from i_addr, i_iorq, i_wr and state, so it is valid in the same cycle as the access.
- DATA write at edge N:
  - Holding register is full after edge N.
  - Shifter loads at edge N+1 (tx_ready=1 again after N+1).
  - o_tx falls after edge N+2.
- TX frame: 10·CLKS_PER_BIT cycles, with each bit held for exactly CLKS_PER_BIT cycles.
- RX: rx_avail rises 1 cycle after the stop-bit sample edge.
- STATUS clear-on-write takes effect at the write-strobe edge. A sticky event in the same cycle as its clear wins, so the bit stays set.

## Structure
- Shared package `z80_io_pkg`:
  - Port offset constants: OFS_DATA, OFS_STATUS, OFS_CTRL.
  - Status bit index constants: ST_RX_AVAIL, ST_RX_FULL, ST_TX_BUSY, ST_TX_READY, ST_OVERRUN, ST_FRAME_ERR.
  - CTRL bit index constants.
  - Enum types for the TX and RX FSM states.
- One sub-module, `sync_fifo`, parameterised on width and depth, with push/pop/full/empty.
- Bus decode and the two FSMs stay in this module.

## Test plan
- After reset: o_tx=1, o_int=0, and a STATUS read returns 8'h08 (tx_ready only).
- With CLKS_PER_BIT=8, write 8'hA5 to port 0x80 → o_tx low 2 cycles after the strobe, then the bit pattern 1,0,1,0,0,1,0,1 at 8 cycles/bit, then stop=1. Total frame 80 cycles.
- Drive serial 8'h3C on i_rx → STATUS bit0=1 → a read of port 0x80 returns 8'h3C → after IORQ drops, STATUS=8'h08.
- Drive 5 frames with RX_DEPTH=4 and no reads → rx_full=1, overrun=1, and four reads return the first four bytes. Write 8'h10 to STATUS → overrun=0.
- Drive a frame with stop=0 → no push and framing error=1. A 2-cycle low glitch on i_rx → no frame, FSM back in IDLE.
- CTRL=8'h01 → o_int rises after an RX push and falls after the pop. CTRL=8'h02 → o_int=1 while tx_ready. Assert i_reset mid-TX-frame → o_tx=1 immediately.

Source files
------------

// File: rtl/z80_io_pkg.sv
// z80_io_pkg: shared constants and state types for the Z80 I/O-port UART.
//   Port offsets within the 4-port block, STATUS/CTRL bit positions,
//   and the TX/RX FSM state enums.
package z80_io_pkg;

    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_CTRL   = 2'd2;

    localparam int ST_RX_AVAIL  = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_BUSY   = 2;
    localparam int ST_TX_READY  = 3;
    localparam int ST_OVERRUN   = 4;
    localparam int ST_FRAME_ERR = 5;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/z80_uart_io_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head output.
//   i_push/i_data : write side (ignored when full unless popping in the same cycle)
//   i_pop         : read side (ignored when empty)
//   o_head        : entry at the read pointer (stale when empty)
//   o_full/o_empty: occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop frees the head slot at the same edge, so a push into a full FIFO is allowed then.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/z80_uart_io.sv
// z80_uart_io: serial console peripheral on the Z80 I/O-port bus.
//   i_addr/i_iorq/i_wr/i_data : CPU I/O cycle; o_data is the combinational read path
//   o_int                     : level interrupt (RX data available / TX holding empty)
//   i_rx/o_tx                 : 8N1 serial lines
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, waiting for the holding register to fill
//   TX_START | sending the start bit
//   TX_DATA  | sending 8 data bits, LSB first
//   TX_STOP  | sending the stop bit; chains straight into START if another byte waits
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronised line
//   RX_START | waiting half a bit to confirm the start bit (high = glitch)
//   RX_DATA  | sampling 8 data bits one bit period apart
//   RX_STOP  | sampling the stop bit; push on 1, framing error on 0
module z80_uart_io
    import z80_io_pkg::*;
#(
    parameter logic [7:0] BASE_PORT    = 8'h80,
    parameter int         CLKS_PER_BIT = 434,
    parameter int         RX_DEPTH     = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_addr,
    input  logic       i_iorq,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_int,
    input  logic       i_rx,
    output logic       o_tx
);
    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             w_sel, w_wr_stb, w_st_wr, w_pop;
    logic             r_sel_q, r_rd_data;
    logic [1:0]       r_ctrl;
    logic [7:0]       w_status;
    logic             r_overrun, r_frame_err;

    tx_state_t        r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift, r_hold;
    logic             r_hold_full, r_tx;

    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic             r_rx_meta, r_rx_sync, r_rx_prev;
    logic             w_rx_push, w_ferr_evt, w_ovr_evt;
    logic [7:0]       w_fifo_head;
    logic             w_fifo_full, w_fifo_empty;

    assign w_sel    = i_iorq & (i_addr[7:2] == BASE_PORT[7:2]);
    assign w_wr_stb = w_sel & i_wr & ~r_sel_q;
    assign w_st_wr  = w_wr_stb & (i_addr[1:0] == OFS_STATUS);
    assign w_pop    = r_rd_data & ~w_sel;
    assign o_tx     = r_tx;
    assign o_int    = (r_ctrl[CTRL_RX_IE] & ~w_fifo_empty) | (r_ctrl[CTRL_TX_IE] & ~r_hold_full);

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_status               = 8'h00;
        w_status[ST_RX_AVAIL]  = ~w_fifo_empty;
        w_status[ST_RX_FULL]   = w_fifo_full;
        w_status[ST_TX_BUSY]   = (r_tx_state != TX_IDLE);
        w_status[ST_TX_READY]  = ~r_hold_full;
        w_status[ST_OVERRUN]   = r_overrun;
        w_status[ST_FRAME_ERR] = r_frame_err;
    end

    always_comb begin
        o_data = 8'h00;
        if (w_sel && !i_wr) begin
            case (i_addr[1:0])
                OFS_DATA:   o_data = w_fifo_empty ? 8'h00 : w_fifo_head;
                OFS_STATUS: o_data = w_status;
                OFS_CTRL:   o_data = {6'b0, r_ctrl};
                default:    o_data = 8'h00;
            endcase
        end
    end

    // Bus tracking: previous select for the write strobe, pending DATA read for pop at read end.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sel_q   <= 1'b0;
            r_rd_data <= 1'b0;
            r_ctrl    <= 2'b00;
        end else begin
            r_sel_q <= w_sel;
            if (w_sel && !i_wr) r_rd_data <= (i_addr[1:0] == OFS_DATA);
            else if (!w_sel)    r_rd_data <= 1'b0;
            if (w_wr_stb && i_addr[1:0] == OFS_CTRL) r_ctrl <= i_data[1:0];
        end
    end

    // An event in the same cycle as its clear keeps the bit set.
    assign w_ovr_evt = w_rx_push & w_fifo_full & ~w_pop;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_ovr_evt  | (r_overrun   & ~(w_st_wr & i_data[ST_OVERRUN]));
            r_frame_err <= w_ferr_evt | (r_frame_err & ~(w_st_wr & i_data[ST_FRAME_ERR]));
        end
    end

    // o_tx is registered from the state, so the line lags the FSM by one cycle;
    // every state lasts exactly CLKS_PER_BIT so bit widths are preserved.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= 3'd0;
            r_tx_shift  <= 8'h00;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_tx        <= 1'b1;
        end else begin
            r_tx <= (r_tx_state == TX_START) ? 1'b0 :
                    (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;
            if (w_wr_stb && i_addr[1:0] == OFS_DATA && !r_hold_full) begin
                r_hold      <= i_data;
                r_hold_full <= 1'b1;
            end
            case (r_tx_state)
                TX_IDLE: if (r_hold_full) begin
                    r_tx_shift  <= r_hold;
                    r_hold_full <= 1'b0;
                    r_tx_cnt    <= BIT_LOAD;
                    r_tx_state  <= TX_START;
                end
                TX_START: if (r_tx_cnt == '0) begin
                    r_tx_cnt   <= BIT_LOAD;
                    r_tx_bit   <= 3'd0;
                    r_tx_state <= TX_DATA;
                end else r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                TX_DATA: if (r_tx_cnt == '0) begin
                    r_tx_cnt   <= BIT_LOAD;
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) r_tx_state <= TX_STOP;
                    else                  r_tx_bit   <= r_tx_bit + 3'd1;
                end else r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                TX_STOP: if (r_tx_cnt == '0) begin
                    if (r_hold_full) begin
                        r_tx_shift  <= r_hold;
                        r_hold_full <= 1'b0;
                        r_tx_cnt    <= BIT_LOAD;
                        r_tx_state  <= TX_START;
                    end else r_tx_state <= TX_IDLE;
                end else r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign w_rx_push  = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) &&  r_rx_sync;
    assign w_ferr_evt = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) && !r_rx_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            case (r_rx_state)
                RX_IDLE: if (r_rx_prev && !r_rx_sync) begin
                    r_rx_cnt   <= HALF_LOAD;
                    r_rx_state <= RX_START;
                end
                RX_START: if (r_rx_cnt == '0) begin
                    if (r_rx_sync) r_rx_state <= RX_IDLE;
                    else begin
                        r_rx_cnt   <= BIT_LOAD;
                        r_rx_bit   <= 3'd0;
                        r_rx_state <= RX_DATA;
                    end
                end else r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                RX_DATA: if (r_rx_cnt == '0) begin
                    r_rx_cnt   <= BIT_LOAD;
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    else                  r_rx_bit   <= r_rx_bit + 3'd1;
                end else r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                RX_STOP: if (r_rx_cnt == '0) r_rx_state <= RX_IDLE;
                         else r_rx_cnt <= r_rx_cnt - CNT_W'(1);
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule
